// File: rtl/exmem_mem_stage.sv
// EX/MEM register, data-memory req/ready access and MEM/WB register; optional MEM_ALIGN_CHECK_EN alignment check.
// Latency: ALU ops 1 cycle EX/MEM -> MEM/WB; memory ops complete on the dmem_ready cycle (or abandon at TIMEOUT).
// Backpressure: mem_stall freezes upstream while WAIT sees no ready; MEM/WB takes bubbles meanwhile.
module exmem_mem_stage #(
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] EX_ALUResult_out,
    input  logic [DATA_W-1:0] EX_StoreData,
    input  logic [4:0]        EX_Rd,
    input  logic              EX_RegWrite,
    input  logic              EX_MemWrite,
    input  logic              EX_read_enable,
    input  logic [3:0]        EX_xfer_size,
    output logic [DATA_W-1:0] EXMEM_ALUResult,
    output logic [4:0]        EXMEM_Rd,
    output logic              EXMEM_RegWrite,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic [3:0]        dmem_size,
    input  logic              dmem_ready,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [4:0]        MEMWB_Rd,
    output logic              RegWrite_fromMEMWB,
    output logic [DATA_W-1:0] WB_MemToRegOut,
    output logic              mem_stall,
    output logic              mem_timeout,
    output logic              align_fault
);

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    localparam logic [7:0] TO_LIM  = 8'(TIMEOUT);
    localparam logic [3:0] SZ_BYTE = 4'b0001;

    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   exmem_alu_q, exmem_alu_d;
    logic [DATA_W-1:0]   exmem_sd_q, exmem_sd_d;
    logic [4:0]          exmem_rd_q, exmem_rd_d;
    logic                exmem_rw_q, exmem_rw_d;
    logic                exmem_mw_q, exmem_mw_d;
    logic                exmem_ld_q, exmem_ld_d;
    logic [3:0]          exmem_sz_q, exmem_sz_d;
    logic [4:0]          memwb_rd_q, memwb_rd_d;
    logic                memwb_rw_q, memwb_rw_d;
    logic [DATA_W-1:0]   memwb_wb_q, memwb_wb_d;
    logic                timeout_q, timeout_d;
    logic                align_q, align_d;

    logic                ex_is_mem, ex_misalign, ex_go;
    logic                timeout_hit, stall;
    logic [DATA_W-1:0]   load_data;

    assign ex_is_mem = EX_MemWrite | EX_read_enable;

`ifdef MEM_ALIGN_CHECK_EN
    // Only byte accesses may be unaligned; every other size counts as 64-bit.
    assign ex_misalign = ex_is_mem && (EX_xfer_size != SZ_BYTE) && (EX_ALUResult_out[2:0] != 3'b000);
`else
    assign ex_misalign = 1'b0;
`endif

    assign ex_go       = ex_is_mem & ~ex_misalign;
    assign timeout_hit = (state_q == S_WAIT) && (cnt_q == TO_LIM);
    assign stall       = (state_q == S_WAIT) && !dmem_ready && !timeout_hit;
    assign load_data   = (exmem_sz_q == SZ_BYTE) ? {{(DATA_W-8){1'b0}}, dmem_rdata[7:0]} : dmem_rdata;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        exmem_alu_d = exmem_alu_q;
        exmem_sd_d  = exmem_sd_q;
        exmem_rd_d  = exmem_rd_q;
        exmem_rw_d  = exmem_rw_q;
        exmem_mw_d  = exmem_mw_q;
        exmem_ld_d  = exmem_ld_q;
        exmem_sz_d  = exmem_sz_q;
        memwb_rd_d  = memwb_rd_q;
        memwb_rw_d  = 1'b0;
        memwb_wb_d  = memwb_wb_q;
        timeout_d   = timeout_q;
        align_d     = 1'b0;

        if (!stall) begin
            exmem_alu_d = EX_ALUResult_out;
            exmem_sd_d  = EX_StoreData;
            exmem_rd_d  = EX_Rd;
            exmem_rw_d  = EX_RegWrite;
            exmem_mw_d  = EX_MemWrite;
            exmem_ld_d  = EX_read_enable;
            exmem_sz_d  = EX_xfer_size;
            align_d     = ex_misalign;
        end

        case (state_q)
            S_IDLE: begin
                // A memory op still sitting here in IDLE was rejected as misaligned: bubble it.
                memwb_rd_d = exmem_rd_q;
                memwb_wb_d = exmem_alu_q;
                memwb_rw_d = exmem_rw_q & ~(exmem_mw_q | exmem_ld_q);
                cnt_d      = 8'd0;
                state_d    = ex_go ? S_WAIT : S_IDLE;
            end
            default: begin
                // Ready wins over a coincident timeout since the data is valid.
                if (dmem_ready) begin
                    memwb_rd_d = exmem_rd_q;
                    memwb_wb_d = exmem_ld_q ? load_data : exmem_alu_q;
                    memwb_rw_d = exmem_rw_q & ~exmem_mw_q;
                    cnt_d      = 8'd0;
                    state_d    = ex_go ? S_WAIT : S_IDLE;
                end else if (timeout_hit) begin
                    timeout_d  = 1'b1;
                    cnt_d      = 8'd0;
                    state_d    = ex_go ? S_WAIT : S_IDLE;
                end else begin
                    cnt_d      = cnt_q + 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            exmem_alu_q <= '0;
            exmem_sd_q  <= '0;
            exmem_rd_q  <= 5'd0;
            exmem_rw_q  <= 1'b0;
            exmem_mw_q  <= 1'b0;
            exmem_ld_q  <= 1'b0;
            exmem_sz_q  <= 4'd0;
            memwb_rd_q  <= 5'd0;
            memwb_rw_q  <= 1'b0;
            memwb_wb_q  <= '0;
            timeout_q   <= 1'b0;
            align_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            exmem_alu_q <= exmem_alu_d;
            exmem_sd_q  <= exmem_sd_d;
            exmem_rd_q  <= exmem_rd_d;
            exmem_rw_q  <= exmem_rw_d;
            exmem_mw_q  <= exmem_mw_d;
            exmem_ld_q  <= exmem_ld_d;
            exmem_sz_q  <= exmem_sz_d;
            memwb_rd_q  <= memwb_rd_d;
            memwb_rw_q  <= memwb_rw_d;
            memwb_wb_q  <= memwb_wb_d;
            timeout_q   <= timeout_d;
            align_q     <= align_d;
        end
    end

    assign EXMEM_ALUResult    = exmem_alu_q;
    assign EXMEM_Rd           = exmem_rd_q;
    assign EXMEM_RegWrite     = exmem_rw_q;
    assign dmem_req           = (state_q == S_WAIT);
    assign dmem_we            = exmem_mw_q;
    assign dmem_addr          = exmem_alu_q;
    assign dmem_wdata         = exmem_sd_q;
    assign dmem_size          = exmem_sz_q;
    assign MEMWB_Rd           = memwb_rd_q;
    assign RegWrite_fromMEMWB = memwb_rw_q;
    assign WB_MemToRegOut     = memwb_wb_q;
    assign mem_stall          = stall;
    assign mem_timeout        = timeout_q;
    assign align_fault        = align_q;

endmodule

// File: tb/tb_exmem_mem_stage.sv
// Directed bench for exmem_mem_stage: table of ALU-only ops plus hand sequences for memory corner cases.
module tb_exmem_mem_stage;

    logic        clk;
    logic        reset;
    logic [63:0] ex_alu, ex_sd;
    logic [4:0]  ex_rd;
    logic        ex_rw, ex_mw, ex_ld;
    logic [3:0]  ex_sz;
    logic [63:0] exmem_alu;
    logic [4:0]  exmem_rd;
    logic        exmem_rw;
    logic        dmem_req, dmem_we;
    logic [63:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_size;
    logic        dmem_ready;
    logic [63:0] dmem_rdata;
    logic [4:0]  memwb_rd;
    logic        memwb_rw;
    logic [63:0] wb_data;
    logic        mem_stall, mem_timeout, align_fault;

    int n_cmp  = 0;
    int n_fail = 0;

    exmem_mem_stage #(.DATA_W(64), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .EX_ALUResult_out(ex_alu), .EX_StoreData(ex_sd), .EX_Rd(ex_rd),
        .EX_RegWrite(ex_rw), .EX_MemWrite(ex_mw), .EX_read_enable(ex_ld), .EX_xfer_size(ex_sz),
        .EXMEM_ALUResult(exmem_alu), .EXMEM_Rd(exmem_rd), .EXMEM_RegWrite(exmem_rw),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_size(dmem_size), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .MEMWB_Rd(memwb_rd), .RegWrite_fromMEMWB(memwb_rw), .WB_MemToRegOut(wb_data),
        .mem_stall(mem_stall), .mem_timeout(mem_timeout), .align_fault(align_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic [63:0] alu;
        logic [4:0]  rd;
        logic        rw;
        logic        rdy;
        logic [63:0] rdata;
        logic [63:0] exp_wb;
        logic [4:0]  exp_rd;
        logic        exp_rw;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ex(input logic [63:0] alu, input logic [63:0] sd, input logic [4:0] rd,
                            input logic rw, input logic mw, input logic ld, input logic [3:0] sz);
        ex_alu = alu; ex_sd = sd; ex_rd = rd;
        ex_rw = rw; ex_mw = mw; ex_ld = ld; ex_sz = sz;
    endtask

    task automatic nop;
        drive_ex(64'd0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0, 4'b1000);
    endtask

    initial begin
        vecs[0] = '{64'h5, 5'd1, 1'b1, 1'b0, 64'h0, 64'h5, 5'd1, 1'b1};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 1'b1, 1'b1, 64'h1234, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 1'b1};
        vecs[2] = '{64'h8000_0000_0000_0000, 5'd7, 1'b0, 1'b0, 64'h0, 64'h8000_0000_0000_0000, 5'd7, 1'b0};
        vecs[3] = '{64'h0123_4567_89AB_CDEF, 5'd15, 1'b1, 1'b1, 64'hCAFE, 64'h0123_4567_89AB_CDEF, 5'd15, 1'b1};

        reset = 1'b0;
        dmem_ready = 1'b0;
        dmem_rdata = 64'd0;
        nop();
        #3;
        chk("reset_req", dmem_req, 0);
        chk("reset_stall", mem_stall, 0);
        chk("reset_rw", memwb_rw, 0);
        chk("reset_wb", wb_data, 0);
        chk("reset_timeout", mem_timeout, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 4; i++) begin
            tick();
            drive_ex(vecs[i].alu, 64'd0, vecs[i].rd, vecs[i].rw, 1'b0, 1'b0, 4'b1000);
            dmem_ready = vecs[i].rdy;
            dmem_rdata = vecs[i].rdata;
            tick();
            @(negedge clk);
            chk($sformatf("v%0d_exmem_alu", i), exmem_alu, vecs[i].alu);
            chk($sformatf("v%0d_exmem_rd", i), {59'd0, exmem_rd}, {59'd0, vecs[i].rd});
            chk($sformatf("v%0d_exmem_rw", i), exmem_rw, vecs[i].rw);
            chk($sformatf("v%0d_stall", i), mem_stall, 0);
            chk($sformatf("v%0d_req", i), dmem_req, 0);
            tick();
            @(negedge clk);
            chk($sformatf("v%0d_wb", i), wb_data, vecs[i].exp_wb);
            chk($sformatf("v%0d_memwb_rd", i), {59'd0, memwb_rd}, {59'd0, vecs[i].exp_rd});
            chk($sformatf("v%0d_memwb_rw", i), memwb_rw, vecs[i].exp_rw);
        end
        dmem_ready = 1'b0;

        // LDURB: zero-wait, byte zero-extended
        tick();
        drive_ex(64'h21, 64'd0, 5'd3, 1'b1, 1'b0, 1'b1, 4'b0001);
        tick();
        nop();
        dmem_ready = 1'b1;
        dmem_rdata = 64'hFFFF_FFAB;
        @(negedge clk);
        chk("ldurb_stall", mem_stall, 0);
        chk("ldurb_req", dmem_req, 1);
        chk("ldurb_size", {60'd0, dmem_size}, 64'd1);
        tick();
        dmem_ready = 1'b0;
        @(negedge clk);
        chk("ldurb_wb", wb_data, 64'hAB);
        chk("ldurb_rd", {59'd0, memwb_rd}, 64'd3);
        chk("ldurb_rw", memwb_rw, 1);

        // STUR with one wait cycle; RegWrite must be forced off
        tick();
        drive_ex(64'h40, 64'h7, 5'd2, 1'b1, 1'b1, 1'b0, 4'b1000);
        tick();
        nop();
        @(negedge clk);
        chk("stur_we", dmem_we, 1);
        chk("stur_wdata", dmem_wdata, 64'h7);
        chk("stur_addr", dmem_addr, 64'h40);
        chk("stur_stall", mem_stall, 1);
        tick();
        dmem_ready = 1'b1;
        @(negedge clk);
        chk("stur_stall_ready", mem_stall, 0);
        tick();
        dmem_ready = 1'b0;
        @(negedge clk);
        chk("stur_rw", memwb_rw, 0);
        chk("stur_req_done", dmem_req, 0);

        // Back-to-back loads: FSM stays in WAIT
        tick();
        drive_ex(64'h8, 64'd0, 5'd4, 1'b1, 1'b0, 1'b1, 4'b1000);
        tick();
        drive_ex(64'h18, 64'd0, 5'd5, 1'b1, 1'b0, 1'b1, 4'b1000);
        dmem_ready = 1'b1;
        dmem_rdata = 64'h111;
        @(negedge clk);
        chk("b2b_stall", mem_stall, 0);
        tick();
        nop();
        dmem_rdata = 64'h222;
        @(negedge clk);
        chk("b2b_req2", dmem_req, 1);
        chk("b2b_addr2", dmem_addr, 64'h18);
        chk("b2b_wb1", wb_data, 64'h111);
        chk("b2b_rd1", {59'd0, memwb_rd}, 64'd4);
        tick();
        dmem_ready = 1'b0;
        @(negedge clk);
        chk("b2b_wb2", wb_data, 64'h222);
        chk("b2b_rd2", {59'd0, memwb_rd}, 64'd5);
        chk("b2b_rw2", memwb_rw, 1);
        chk("b2b_idle", dmem_req, 0);

        // Timeout: ready never returns, TIMEOUT = 4
        tick();
        drive_ex(64'h30, 64'd0, 5'd6, 1'b1, 1'b0, 1'b1, 4'b1000);
        tick();
        nop();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("to_stall%0d", k), mem_stall, 1);
            tick();
        end
        @(negedge clk);
        chk("to_stall_end", mem_stall, 0);
        chk("to_req_end", dmem_req, 1);
        tick();
        @(negedge clk);
        chk("to_flag", mem_timeout, 1);
        chk("to_rw", memwb_rw, 0);
        chk("to_idle", dmem_req, 0);
        tick();
        tick();
        @(negedge clk);
        chk("to_sticky", mem_timeout, 1);

        // LDUR with 3 wait cycles, also shows the counter restarted
        tick();
        drive_ex(64'h10, 64'd0, 5'd2, 1'b1, 1'b0, 1'b1, 4'b1000);
        tick();
        nop();
        @(negedge clk);
        chk("ldur_stall1", mem_stall, 1);
        chk("ldur_addr", dmem_addr, 64'h10);
        chk("ldur_we", dmem_we, 0);
        tick();
        @(negedge clk);
        chk("ldur_stall2", mem_stall, 1);
        chk("ldur_bubble", memwb_rw, 0);
        tick();
        @(negedge clk);
        chk("ldur_stall3", mem_stall, 1);
        tick();
        dmem_ready = 1'b1;
        dmem_rdata = 64'hDEAD_BEEF;
        @(negedge clk);
        chk("ldur_stall4", mem_stall, 0);
        tick();
        dmem_ready = 1'b0;
        @(negedge clk);
        chk("ldur_wb", wb_data, 64'hDEAD_BEEF);
        chk("ldur_rw", memwb_rw, 1);
        chk("ldur_rd", {59'd0, memwb_rd}, 64'd2);

        // Misaligned 64-bit load at 0x13
        tick();
        drive_ex(64'h13, 64'd0, 5'd8, 1'b1, 1'b0, 1'b1, 4'b1000);
        tick();
        nop();
`ifdef MEM_ALIGN_CHECK_EN
        @(negedge clk);
        chk("al_fault", align_fault, 1);
        chk("al_req", dmem_req, 0);
        chk("al_stall", mem_stall, 0);
        tick();
        @(negedge clk);
        chk("al_fault_pulse", align_fault, 0);
        chk("al_rw", memwb_rw, 0);
`else
        dmem_ready = 1'b1;
        dmem_rdata = 64'h55;
        @(negedge clk);
        chk("al_fault", align_fault, 0);
        chk("al_req", dmem_req, 1);
        chk("al_addr", dmem_addr, 64'h13);
        tick();
        dmem_ready = 1'b0;
        @(negedge clk);
        chk("al_wb", wb_data, 64'h55);
        chk("al_rw", memwb_rw, 1);
`endif

        // Asynchronous reset in the middle of WAIT
        tick();
        drive_ex(64'h20, 64'h9, 5'd9, 1'b1, 1'b1, 1'b0, 4'b1000);
        tick();
        nop();
        @(negedge clk);
        chk("rst_pre_req", dmem_req, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_req", dmem_req, 0);
        chk("rst_stall", mem_stall, 0);
        chk("rst_timeout", mem_timeout, 0);
        chk("rst_exmem_alu", exmem_alu, 0);
        chk("rst_we", dmem_we, 0);
        chk("rst_wdata", dmem_wdata, 0);
        chk("rst_wb", wb_data, 0);
        chk("rst_rd", {59'd0, memwb_rd}, 0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
